// File: rtl/m_simple_req.sv
// Single-outstanding requester: turns one read/write command into a header
// (+ data) beat on the request stream and checks the completer's response.
module m_simple_req #(
    parameter              NAME   = "M_SIMPLE_REQ",
    parameter logic [7:0]  SRC_ID = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:3] cmd_addr,
    input  logic [63:0] cmd_wdata,
    input  logic [4:0]  cmd_strobes,
    output logic        rsp_valid,
    output logic [63:0] rsp_rdata,
    output logic        rsp_error,
    output logic [63:0] O_TDATA,
    output logic        O_TVALID,
    input  logic        O_TREADY,
    output logic        O_TLAST,
    input  logic [63:0] I_TDATA,
    input  logic        I_TVALID,
    output logic        I_TREADY,
    input  logic        I_TLAST
);

    // NAME only labels the instance in simulation messages.
    if ($bits(NAME) == 0) begin : g_unnamed
    end

    typedef enum logic [2:0] {IDLE, HDR, WDATA, WAIT, RDATA, RESP} state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        r_write;
    logic [31:3] r_addr;
    logic [63:0] r_wdata;
    logic [4:0]  r_strobes;
    logic        r_err;
    logic        r_got;
    logic [63:0] r_rdata;

    logic        w_accept;
    logic        w_set_err;
    logic        w_capture;
    logic        w_hdr_bad;
    logic [1:0]  w_req_type;
    logic [1:0]  w_rsp_type;
    logic [63:0] w_hdr;

    assign w_req_type = r_write ? 2'b01 : 2'b00;
    assign w_rsp_type = r_write ? 2'b11 : 2'b10;
    assign w_hdr      = {r_strobes, 3'b000, SRC_ID, 8'h00, 6'b000000, w_req_type, r_addr, 3'b000};
    assign w_hdr_bad  = (I_TDATA[55:48] != SRC_ID) || (I_TDATA[31:3] != r_addr) ||
                        (I_TDATA[33:32] != w_rsp_type);
    assign w_accept   = cmd_valid && cmd_ready;
    assign rsp_rdata  = r_rdata;

    always_comb begin
        w_state_next = r_state;
        cmd_ready    = 1'b0;
        O_TVALID     = 1'b0;
        O_TDATA      = 64'd0;
        O_TLAST      = 1'b0;
        I_TREADY     = 1'b0;
        rsp_valid    = 1'b0;
        rsp_error    = 1'b0;
        w_set_err    = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            IDLE: begin
                cmd_ready = !reset;
                if (cmd_valid && !reset) w_state_next = HDR;
            end
            HDR: begin
                O_TVALID = 1'b1;
                O_TDATA  = w_hdr;
                O_TLAST  = !r_write;
                if (O_TREADY) w_state_next = r_write ? WDATA : WAIT;
            end
            WDATA: begin
                O_TVALID = 1'b1;
                O_TDATA  = r_wdata;
                O_TLAST  = 1'b1;
                if (O_TREADY) w_state_next = WAIT;
            end
            WAIT: begin
                I_TREADY = 1'b1;
                if (I_TVALID) begin
                    // Writes expect a lone header; reads expect header then data.
                    w_set_err    = w_hdr_bad || (r_write != I_TLAST);
                    w_state_next = I_TLAST ? RESP : RDATA;
                end
            end
            RDATA: begin
                I_TREADY = 1'b1;
                if (I_TVALID) begin
                    if (r_got)         w_set_err = 1'b1;
                    else if (!r_write) w_capture = 1'b1;
                    if (I_TLAST) w_state_next = RESP;
                end
            end
            RESP: begin
                rsp_valid    = 1'b1;
                rsp_error    = r_err;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_write   <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= 64'd0;
            r_strobes <= 5'd0;
            r_err     <= 1'b0;
            r_got     <= 1'b0;
            r_rdata   <= 64'd0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_write   <= cmd_write;
                r_addr    <= cmd_addr;
                r_wdata   <= cmd_wdata;
                r_strobes <= cmd_strobes;
                r_err     <= 1'b0;
                r_got     <= 1'b0;
            end
            if (w_set_err) r_err <= 1'b1;
            if (w_capture) r_rdata <= I_TDATA;
            if (r_state == RDATA && I_TVALID) r_got <= 1'b1;
        end
    end

endmodule

// File: tb/tb_m_simple_req.sv
// Directed table-driven bench for m_simple_req plus stall and reset sequences.
module tb_m_simple_req;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:3] cmd_addr;
    logic [63:0] cmd_wdata;
    logic [4:0]  cmd_strobes;
    logic        rsp_valid, rsp_error;
    logic [63:0] rsp_rdata;
    logic [63:0] O_TDATA, I_TDATA;
    logic        O_TVALID, O_TREADY, O_TLAST;
    logic        I_TVALID, I_TREADY, I_TLAST;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    m_simple_req #(.NAME("DUT"), .SRC_ID(8'hab)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strobes(cmd_strobes),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .O_TDATA(O_TDATA), .O_TVALID(O_TVALID), .O_TREADY(O_TREADY), .O_TLAST(O_TLAST),
        .I_TDATA(I_TDATA), .I_TVALID(I_TVALID), .I_TREADY(I_TREADY), .I_TLAST(I_TLAST)
    );

    typedef struct {
        logic        wr;
        logic [28:0] addr;
        logic [63:0] wdata;
        logic [4:0]  strb;
        logic [63:0] exp_hdr;
        logic [7:0]  rsp_id;
        logic [1:0]  rsp_type;
        logic [28:0] rsp_addr;
        logic        hdr_last;
        int          ndata;
        logic [63:0] rdata0;
        logic        exp_err;
        logic [63:0] exp_rdata;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic issue_cmd(input logic wr, input logic [28:0] addr,
                             input logic [63:0] wdata, input logic [4:0] strb);
        @(negedge clk);
        chk("cmd_ready_idle", {63'd0, cmd_ready}, 64'd1);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr;
        cmd_wdata = wdata; cmd_strobes = strb;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Called with the DUT in WAIT at a negedge; returns at the RESP negedge.
    task automatic send_rsp(input logic [63:0] hdr, input logic hlast,
                            input int ndata, input logic [63:0] d0);
        chk("i_tready_wait", {63'd0, I_TREADY}, 64'd1);
        chk("o_tvalid_wait", {63'd0, O_TVALID}, 64'd0);
        I_TVALID = 1'b1; I_TDATA = hdr; I_TLAST = hlast;
        for (int k = 0; k < ndata; k++) begin
            @(negedge clk);
            chk("i_tready_rdata", {63'd0, I_TREADY}, 64'd1);
            I_TDATA = d0 + 64'(k); I_TLAST = (k == ndata - 1);
        end
        @(negedge clk);
        I_TVALID = 1'b0; I_TLAST = 1'b0;
    endtask

    task automatic check_resp(input logic err, input logic [63:0] rdata);
        chk("rsp_valid", {63'd0, rsp_valid}, 64'd1);
        chk("rsp_error", {63'd0, rsp_error}, {63'd0, err});
        chk("rsp_rdata", rsp_rdata, rdata);
        chk("cmd_ready_resp", {63'd0, cmd_ready}, 64'd0);
        @(negedge clk);
        chk("rsp_valid_pulse", {63'd0, rsp_valid}, 64'd0);
        chk("rsp_error_idle", {63'd0, rsp_error}, 64'd0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic [63:0] rh;
        O_TREADY = 1'b1;
        issue_cmd(v.wr, v.addr, v.wdata, v.strb);
        chk("hdr_valid", {63'd0, O_TVALID}, 64'd1);
        chk("hdr_data", O_TDATA, v.exp_hdr);
        chk("hdr_last", {63'd0, O_TLAST}, {63'd0, !v.wr});
        @(negedge clk);
        if (v.wr) begin
            chk("wdata_valid", {63'd0, O_TVALID}, 64'd1);
            chk("wdata_data", O_TDATA, v.wdata);
            chk("wdata_last", {63'd0, O_TLAST}, 64'd1);
            @(negedge clk);
        end
        rh = {8'h00, v.rsp_id, 8'h00, 6'd0, v.rsp_type, v.rsp_addr, 3'b000};
        send_rsp(rh, v.hdr_last, v.ndata, v.rdata0);
        check_resp(v.exp_err, v.exp_rdata);
        $display("[TB] vector %0d wr=%0b addr=%h done, rsp_error=%0b rdata=%h",
                 idx, v.wr, v.addr, v.exp_err, v.exp_rdata);
    endtask

    initial begin
        vecs[0] = '{1'b1, 29'd1234,  64'hdeadbeefcafebabe, 5'h1f, 64'hF8AB_0001_0000_2690,
                    8'hab, 2'd3, 29'd1234,  1'b1, 0, 64'd0, 1'b0, 64'd0};
        vecs[1] = '{1'b0, 29'h100,   64'd0,                5'h1f, 64'hF8AB_0000_0000_0800,
                    8'hab, 2'd2, 29'h100,   1'b0, 1, 64'h0123456789abcdef, 1'b0, 64'h0123456789abcdef};
        vecs[2] = '{1'b1, 29'd1234,  64'd0,                5'h1f, 64'hF8AB_0001_0000_2690,
                    8'hac, 2'd3, 29'd1234,  1'b1, 0, 64'd0, 1'b1, 64'h0123456789abcdef};
        vecs[3] = '{1'b0, 29'h100,   64'd0,                5'h01, 64'h08AB_0000_0000_0800,
                    8'hab, 2'd2, 29'h100,   1'b0, 3, 64'h1111, 1'b1, 64'h1111};
        vecs[4] = '{1'b0, 29'h1,     64'd0,                5'h00, 64'h00AB_0000_0000_0008,
                    8'hab, 2'd2, 29'h1,     1'b1, 0, 64'd0, 1'b1, 64'h1111};
        vecs[5] = '{1'b1, 29'h1FFFFFFF, 64'hffff0000ffff0000, 5'h10, 64'h80AB_0001_FFFF_FFF8,
                    8'hab, 2'd2, 29'h1FFFFFFF, 1'b1, 0, 64'd0, 1'b1, 64'h1111};
        vecs[6] = '{1'b0, 29'h2,     64'd0,                5'h1f, 64'hF8AB_0000_0000_0010,
                    8'hab, 2'd2, 29'h3,     1'b0, 1, 64'h2222, 1'b1, 64'h2222};
        vecs[7] = '{1'b0, 29'h2,     64'd0,                5'h1f, 64'hF8AB_0000_0000_0010,
                    8'hab, 2'd2, 29'h2,     1'b0, 1, 64'ha5a55a5a0f0ff0f0, 1'b0, 64'ha5a55a5a0f0ff0f0};

        reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_wdata = '0; cmd_strobes = '0; O_TREADY = 1'b0;
        I_TVALID = 1'b0; I_TDATA = '0; I_TLAST = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", {63'd0, cmd_ready}, 64'd0);
        chk("rst_o_tvalid", {63'd0, O_TVALID}, 64'd0);
        chk("rst_o_tdata", O_TDATA, 64'd0);
        chk("rst_o_tlast", {63'd0, O_TLAST}, 64'd0);
        chk("rst_i_tready", {63'd0, I_TREADY}, 64'd0);
        chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("rst_rsp_error", {63'd0, rsp_error}, 64'd0);
        chk("rst_rsp_rdata", rsp_rdata, 64'd0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // Back-pressure in HDR and WDATA with stray response beats offered.
        O_TREADY = 1'b0;
        I_TVALID = 1'b1; I_TDATA = 64'h1234; I_TLAST = 1'b1;
        issue_cmd(1'b1, 29'd5, 64'h5555_6666_7777_8888, 5'h1f);
        for (int c = 0; c < 5; c++) begin
            chk("stall_hdr_valid", {63'd0, O_TVALID}, 64'd1);
            chk("stall_hdr_data", O_TDATA, 64'hF8AB_0001_0000_0028);
            chk("stall_hdr_last", {63'd0, O_TLAST}, 64'd0);
            chk("stall_i_tready", {63'd0, I_TREADY}, 64'd0);
            @(negedge clk);
        end
        O_TREADY = 1'b1;
        @(negedge clk);
        O_TREADY = 1'b0;
        for (int c = 0; c < 5; c++) begin
            chk("stall_wd_valid", {63'd0, O_TVALID}, 64'd1);
            chk("stall_wd_data", O_TDATA, 64'h5555_6666_7777_8888);
            chk("stall_wd_last", {63'd0, O_TLAST}, 64'd1);
            chk("stall_wd_i_tready", {63'd0, I_TREADY}, 64'd0);
            @(negedge clk);
        end
        I_TVALID = 1'b0; I_TLAST = 1'b0;
        O_TREADY = 1'b1;
        @(negedge clk);
        chk("stall_no_dup", {63'd0, O_TVALID}, 64'd0);
        send_rsp({8'h00, 8'hab, 8'h00, 6'd0, 2'd3, 29'd5, 3'b000}, 1'b1, 0, 64'd0);
        check_resp(1'b0, 64'ha5a55a5a0f0ff0f0);
        $display("[TB] stall sequence done");

        // Reset while waiting for the response abandons the transaction.
        issue_cmd(1'b0, 29'h40, 64'd0, 5'h1f);
        @(negedge clk);
        chk("pre_rst_wait", {63'd0, I_TREADY}, 64'd1);
        reset = 1'b1;
        chk("rst_mid_cmd_ready", {63'd0, cmd_ready}, 64'd0);
        @(negedge clk);
        chk("rst_mid_i_tready", {63'd0, I_TREADY}, 64'd0);
        chk("rst_mid_o_tvalid", {63'd0, O_TVALID}, 64'd0);
        chk("rst_mid_o_tdata", O_TDATA, 64'd0);
        chk("rst_mid_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("rst_mid_rsp_rdata", rsp_rdata, 64'd0);
        chk("rst_mid_cmd_ready", {63'd0, cmd_ready}, 64'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        vecs[0].exp_rdata = 64'd0;
        run_vec(vecs[0], 8);
        $display("[TB] reset-in-wait sequence done");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
